// File: rtl/mult_serial_frontend.sv
// -----------------------------------------------------------------------------
// mult_serial_frontend
//
// Bus-side loader/unloader for the 16x16 shift-add multiplication unit.
// A 32-bit serial frame (a then b, MSB first) is shifted in. The operands are
// then held stable while mult_start stays high until the multiplier's result
// can be trusted. The 32-bit product is returned as a serial frame, MSB first.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_bit/rx_valid        serial operand input (ready/valid)
//   rx_ready               high only while receiving
//   tx_bit/tx_valid        serial product output (ready/valid)
//   tx_ready               bus accepts tx_bit this cycle
//   mult_a, mult_b         operands to the multiplier (change only in RECV)
//   mult_start             held high for the whole multiply
//   mult_c, mult_done      product and (sticky) done flag from the multiplier
//   busy                   high in RUN or SEND
//   timeout_err            sticky: last operation timed out
// -----------------------------------------------------------------------------
module mult_serial_frontend #(
    parameter int MIN_LAT = 34,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_bit,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_bit,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] mult_a,
    output logic [15:0] mult_b,
    output logic        mult_start,
    input  logic [31:0] mult_c,
    input  logic        mult_done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_RUN  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_MIN_LAT = CNT_W'(MIN_LAT);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_bit_cnt;
    logic [4:0]         w_bit_cnt_nxt;
    logic [CNT_W-1:0]   r_run_cnt;
    logic [CNT_W-1:0]   w_run_cnt_nxt;
    logic [15:0]        r_a;
    logic [15:0]        w_a_nxt;
    logic [15:0]        r_b;
    logic [15:0]        w_b_nxt;
    logic [31:0]        r_prod;
    logic [31:0]        w_prod_nxt;
    logic               r_timeout_err;
    logic               w_timeout_err_nxt;
    logic               r_rx_ready;
    logic               r_tx_valid;
    logic               r_mult_start;
    logic               r_busy;

    // Saturating increment of the RUN cycle counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v != L_CNT_MAX) begin
            res = v + CNT_W'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Next-state and datapath decode for the RECV/RUN/SEND sequencer.
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_run_cnt_nxt     = r_run_cnt;
        w_a_nxt           = r_a;
        w_b_nxt           = r_b;
        w_prod_nxt        = r_prod;
        w_timeout_err_nxt = r_timeout_err;
        case (r_state)
            ST_RECV: begin
                // r_rx_ready is low during the first cycle out of reset, so no
                // bit can be taken before the block advertises readiness.
                if (rx_valid && r_rx_ready) begin
                    if (r_bit_cnt == 5'd0) begin
                        w_timeout_err_nxt = 1'b0;
                    end else begin
                        w_timeout_err_nxt = r_timeout_err;
                    end
                    // Bits 0-15 build a, bits 16-31 build b, first bit lands at [15].
                    if (r_bit_cnt[4] == 1'b0) begin
                        w_a_nxt = {r_a[14:0], rx_bit};
                    end else begin
                        w_b_nxt = {r_b[14:0], rx_bit};
                    end
                    if (r_bit_cnt == 5'd31) begin
                        w_state_nxt   = ST_RUN;
                        w_bit_cnt_nxt = 5'd0;
                        w_run_cnt_nxt = {CNT_W{1'b0}};
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt;
                end
            end
            ST_RUN: begin
                w_run_cnt_nxt = sat_inc(r_run_cnt);
                // mult_done is sticky from the previous operation; only trust it
                // once enough cycles have elapsed. Done has priority over timeout.
                if (mult_done && (r_run_cnt >= L_MIN_LAT)) begin
                    w_prod_nxt  = mult_c;
                    w_state_nxt = ST_SEND;
                end else if (r_run_cnt == L_TIMEOUT) begin
                    w_prod_nxt        = 32'hFFFF_FFFF;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = ST_SEND;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SEND: begin
                if (r_tx_valid && tx_ready) begin
                    w_prod_nxt = {r_prod[30:0], 1'b0};
                    if (r_bit_cnt == 5'd31) begin
                        w_state_nxt   = ST_RECV;
                        w_bit_cnt_nxt = 5'd0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end else begin
                    w_prod_nxt = r_prod;
                end
            end
            default: begin
                w_state_nxt   = ST_RECV;
                w_bit_cnt_nxt = 5'd0;
            end
        endcase
    end

    // State, counters, operand/product registers and registered control outputs.
    // Control outputs are decoded from the next state so they line up with the
    // state register while still reading 0 throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RECV;
            r_bit_cnt     <= 5'd0;
            r_run_cnt     <= {CNT_W{1'b0}};
            r_a           <= 16'd0;
            r_b           <= 16'd0;
            r_prod        <= 32'd0;
            r_timeout_err <= 1'b0;
            r_rx_ready    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_mult_start  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_run_cnt     <= w_run_cnt_nxt;
            r_a           <= w_a_nxt;
            r_b           <= w_b_nxt;
            r_prod        <= w_prod_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_rx_ready    <= (w_state_nxt == ST_RECV);
            r_tx_valid    <= (w_state_nxt == ST_SEND);
            r_mult_start  <= (w_state_nxt == ST_RUN);
            r_busy        <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_SEND);
        end
    end

    assign rx_ready    = r_rx_ready;
    assign tx_valid    = r_tx_valid;
    assign tx_bit      = r_prod[31];
    assign mult_a      = r_a;
    assign mult_b      = r_b;
    assign mult_start  = r_mult_start;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/mult_serial_frontend.md
Name: mult_serial_frontend

Overview:
- Bus-side loader/unloader for the 16x16 shift-add multiplication unit.
- Receives a and b as a 32-bit bit-serial frame from the bus, then holds start to the multiplier until its result is valid.
- Captures the 32-bit product and returns it as a 32-bit bit-serial frame.
- Sits between the SDSU bus slave port and the Multiplication unit; owns all sequencing, so the multiplier only ever sees stable operands and a held start.

Parameters:
- MIN_LAT, 34: cycles in RUN before mult_done is trusted. The multiplier's done flag is sticky from the previous operation; this masks that stale value.
- TIMEOUT, 255: cycles in RUN after which the operation is abandoned. Must be > MIN_LAT.
- CNT_W, 8: width of the RUN cycle counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_bit  in  1  serial operand bit, MSB first
- rx_valid  in  1  rx_bit valid
- rx_ready  out  1  block accepts rx_bit this cycle
- tx_bit  out  1  serial product bit, MSB first
- tx_valid  out  1  tx_bit valid
- tx_ready  in  1  bus accepts tx_bit this cycle
- mult_a  out  16  operand a to multiplier
- mult_b  out  16  operand b to multiplier
- mult_start  out  1  start to multiplier, held for the whole operation
- mult_c  in  32  product from multiplier
- mult_done  in  1  multiplier calculated flag
- busy  out  1  high in RUN or SEND
- timeout_err  out  1  sticky: last operation timed out

Behaviour:
- Reset, asynchronous on rst_n low:
  - State RECV; bit counter and RUN counter 0.
  - mult_a, mult_b, the product shift register, rx_ready, tx_bit, tx_valid, mult_start, busy and timeout_err all 0.
  - rx_ready rises in the first cycle after rst_n deasserts.
- Reset mid-operation (any state) aborts immediately. No partial frame is retained; the next frame starts from bit 0.
- States: RECV, RUN, SEND, all registered. Control outputs are decoded from the state register: rx_ready = (RECV), tx_valid = (SEND), mult_start = (RUN), busy = (RUN or SEND).
- RECV:
  - A bit is accepted when rx_valid && rx_ready.
  - Accepted bits 0-15 shift into mult_a from the LSB end, so the first bit ends up as a[15]. Bits 16-31 fill mult_b the same way.
  - rx_valid gaps are allowed and do not reset the bit count.
  - First accepted bit of a frame clears timeout_err.
  - 32nd accepted bit: next state RUN, RUN counter cleared.
  - mult_a and mult_b change only in RECV.
- RUN:
  - mult_start = 1. RUN counter increments every cycle, saturating.
  - If mult_done = 1 and counter >= MIN_LAT: latch mult_c into the product shift register, go to SEND. mult_start is 0 the following cycle.
  - Else if counter == TIMEOUT: load product register with 0xFFFF_FFFF, set timeout_err, go to SEND.
  - If both conditions hold in the same cycle, done wins and timeout_err is not set.
  - mult_done before MIN_LAT is ignored.
- SEND:
  - tx_bit = product register bit 31.
  - On tx_valid && tx_ready: shift left by 1 and increment the bit counter.
  - tx_bit is stable while tx_ready is low.
  - After the 32nd accepted bit: go to RECV with bit counter 0. rx_ready is 1 the next cycle.
- rx_valid is ignored (rx_ready = 0) in RUN and SEND; the bus must hold its bits.
- Minimum frame latency, last rx bit to first tx_valid: MIN_LAT + 1 cycles.
- Arithmetic: unsigned throughout. The product is passed through unmodified; the block does no arithmetic on it.

Test Plan:
- Send a=0x0003, b=0x0005 with rx_valid always high, model multiplier of 33 cycles, tx_ready=1 -> tx stream 0x0000000F MSB first; timeout_err=0; busy low after 32 tx bits.
- Send a=0xFFFF, b=0xFFFF with random rx_valid gaps and random tx_ready backpressure -> product 0xFFFE0001; tx_bit never changes while tx_ready=0; no bit lost or duplicated.
- Hold mult_done=1 continuously (stale done), a=0x0010, b=0x0010, product model valid only at cycle 33 -> capture no earlier than MIN_LAT cycles into RUN; result 0x00000100.
- Tie mult_done=0 -> after TIMEOUT cycles the tx stream is 0xFFFFFFFF and timeout_err=1. A following good frame a=2, b=3 clears timeout_err on its first rx bit and returns 0x00000006.
- Pulse rst_n low mid-RUN and again mid-SEND (bit 10) -> all outputs 0 asynchronously; next frame a=0x1234, b=0x0002 returns 0x00002468 correctly.
- mult_done rising in exactly the TIMEOUT cycle, with counter >= MIN_LAT -> mult_c captured, timeout_err stays 0.
